// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the controller FSM encodings, forwarding-select encodings and the
// core's instruction-field widths.
package pipeline_pkg;

    localparam int unsigned AWIDTH       = 5;
    localparam int unsigned OPCODE_WIDTH = 6;
    localparam int unsigned FUNCT_WIDTH  = 6;
    localparam int unsigned FWD_WIDTH    = 2;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } pl_state_e;

    // Execute-stage operand source selects
    localparam logic [FWD_WIDTH-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_WIDTH-1:0] FWD_MS = 2'b01;
    localparam logic [FWD_WIDTH-1:0] FWD_WS = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding comparator for both execute operands.
// Ports:
//   es_rs, es_rt          - source registers of the instruction in execute
//   ms_rd, ms_regwrite    - memory-stage destination and write enable
//   ws_rd, ws_regwrite    - writeback-stage destination and write enable
//   fwd_a, fwd_b          - operand selects (regfile / memory / writeback)
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned AWIDTH = pipeline_pkg::AWIDTH
) (
    input  logic [AWIDTH-1:0]    es_rs,
    input  logic [AWIDTH-1:0]    es_rt,
    input  logic [AWIDTH-1:0]    ms_rd,
    input  logic                 ms_regwrite,
    input  logic [AWIDTH-1:0]    ws_rd,
    input  logic                 ws_regwrite,
    output logic [FWD_WIDTH-1:0] fwd_a,
    output logic [FWD_WIDTH-1:0] fwd_b
);

    // Memory stage holds the younger result, so it wins over writeback.
    // Register 0 is hardwired and never forwarded.
    function automatic logic [FWD_WIDTH-1:0] pick_src(input logic [AWIDTH-1:0] src);
        logic [FWD_WIDTH-1:0] sel;
        sel = FWD_RF;
        if (ms_regwrite && (ms_rd != '0) && (ms_rd == src)) begin
            sel = FWD_MS;
        end else if (ws_regwrite && (ws_rd != '0) && (ws_rd == src)) begin
            sel = FWD_WS;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = pick_src(es_rs);
        fwd_b = pick_src(es_rt);
    end

endmodule

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Produces stage enables and bubble strobes for fetch/decode/execute,
// resolves load-use, taken-branch and mul/div hazards, supplies execute
// forwarding selects and counts fetch-stall cycles (saturating).
// Ports:
//   pl_clk, pl_rst                       - clock, async active-high reset
//   pl_i_ds_*, pl_i_es_*, pl_i_ms_*,
//   pl_i_ws_*                            - per-stage register/control info
//   pl_i_md_done, pl_i_halt              - mul/div completion, halt request
//   pl_o_fs_ce/ds_ce/es_ce               - stage advance enables (comb)
//   pl_o_ds_flush/es_flush               - bubble strobes (comb)
//   pl_o_fwd_a/fwd_b                     - operand selects (comb)
//   pl_o_stall_cnt                       - saturating stall-cycle count
//   pl_o_halted                          - controller is halted
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int unsigned AWIDTH    = pipeline_pkg::AWIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 pl_clk,
    input  logic                 pl_rst,
    input  logic [AWIDTH-1:0]    pl_i_ds_rs,
    input  logic [AWIDTH-1:0]    pl_i_ds_rt,
    input  logic [AWIDTH-1:0]    pl_i_es_rs,
    input  logic [AWIDTH-1:0]    pl_i_es_rt,
    input  logic [AWIDTH-1:0]    pl_i_es_rd,
    input  logic                 pl_i_es_memread,
    input  logic                 pl_i_es_change_pc,
    input  logic                 pl_i_es_md_start,
    input  logic                 pl_i_md_done,
    input  logic [AWIDTH-1:0]    pl_i_ms_rd,
    input  logic [AWIDTH-1:0]    pl_i_ws_rd,
    input  logic                 pl_i_ms_regwrite,
    input  logic                 pl_i_ws_regwrite,
    input  logic                 pl_i_halt,
    output logic                 pl_o_fs_ce,
    output logic                 pl_o_ds_ce,
    output logic                 pl_o_es_ce,
    output logic                 pl_o_ds_flush,
    output logic                 pl_o_es_flush,
    output logic [FWD_WIDTH-1:0] pl_o_fwd_a,
    output logic [FWD_WIDTH-1:0] pl_o_fwd_b,
    output logic [CNT_WIDTH-1:0] pl_o_stall_cnt,
    output logic                 pl_o_halted
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    pl_state_e            state;
    pl_state_e            state_nx;
    logic                 halt_pend;
    logic                 halt_req;
    logic                 load_use;
    logic [FWD_WIDTH-1:0] fwd_a_raw;
    logic [FWD_WIDTH-1:0] fwd_b_raw;

    forward_unit #(
        .AWIDTH(AWIDTH)
    ) u_forward_unit (
        .es_rs       (pl_i_es_rs),
        .es_rt       (pl_i_es_rt),
        .ms_rd       (pl_i_ms_rd),
        .ms_regwrite (pl_i_ms_regwrite),
        .ws_rd       (pl_i_ws_rd),
        .ws_regwrite (pl_i_ws_regwrite),
        .fwd_a       (fwd_a_raw),
        .fwd_b       (fwd_b_raw)
    );

    assign load_use = pl_i_es_memread && (pl_i_es_rd != '0) &&
                      ((pl_i_es_rd == pl_i_ds_rs) || (pl_i_es_rd == pl_i_ds_rt));

    // A halt seen while waiting on mul/div is remembered and acted on in RUN.
    assign halt_req = pl_i_halt || halt_pend;

    // State register
    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Deferred halt capture
    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            halt_pend <= 1'b0;
        end else if ((state == ST_MD_WAIT) && pl_i_halt) begin
            halt_pend <= 1'b1;
        end else if (state == ST_RUN) begin
            halt_pend <= 1'b0;
        end
    end

    // Next state and stage controls
    always_comb begin
        state_nx      = state;
        pl_o_fs_ce    = 1'b0;
        pl_o_ds_ce    = 1'b0;
        pl_o_es_ce    = 1'b0;
        pl_o_ds_flush = 1'b0;
        pl_o_es_flush = 1'b0;
        pl_o_fwd_a    = fwd_a_raw;
        pl_o_fwd_b    = fwd_b_raw;

        unique case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nx = ST_HALT;
                end else if (pl_i_es_change_pc) begin
                    // Squash the wrong-path instructions; a load-use consumer
                    // among them is irrelevant.
                    pl_o_fs_ce    = 1'b1;
                    pl_o_ds_ce    = 1'b1;
                    pl_o_es_ce    = 1'b1;
                    pl_o_ds_flush = 1'b1;
                    pl_o_es_flush = 1'b1;
                end else if (pl_i_es_md_start) begin
                    state_nx = ST_MD_WAIT;
                end else if (load_use) begin
                    // Hold fetch/decode, let the load advance with a bubble behind it.
                    pl_o_es_ce    = 1'b1;
                    pl_o_es_flush = 1'b1;
                end else begin
                    pl_o_fs_ce = 1'b1;
                    pl_o_ds_ce = 1'b1;
                    pl_o_es_ce = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (pl_i_md_done) begin
                    state_nx = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nx = ST_HALT;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        if (pl_rst) begin
            pl_o_fs_ce    = 1'b0;
            pl_o_ds_ce    = 1'b0;
            pl_o_es_ce    = 1'b0;
            pl_o_ds_flush = 1'b0;
            pl_o_es_flush = 1'b0;
            pl_o_fwd_a    = FWD_RF;
            pl_o_fwd_b    = FWD_RF;
        end
    end

    // Saturating fetch-stall counter, frozen while halted
    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            pl_o_stall_cnt <= '0;
        end else if (!pl_o_fs_ce && (state != ST_HALT) && (pl_o_stall_cnt != CNT_MAX)) begin
            pl_o_stall_cnt <= pl_o_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign pl_o_halted = (state == ST_HALT);

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (CNT_WIDTH = 4).
module tb_pipeline_control;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          pl_clk = 1'b0;
    logic          pl_rst;
    logic [AW-1:0] pl_i_ds_rs, pl_i_ds_rt, pl_i_es_rs, pl_i_es_rt, pl_i_es_rd;
    logic          pl_i_es_memread, pl_i_es_change_pc, pl_i_es_md_start, pl_i_md_done;
    logic [AW-1:0] pl_i_ms_rd, pl_i_ws_rd;
    logic          pl_i_ms_regwrite, pl_i_ws_regwrite, pl_i_halt;
    logic          pl_o_fs_ce, pl_o_ds_ce, pl_o_es_ce, pl_o_ds_flush, pl_o_es_flush;
    logic [1:0]    pl_o_fwd_a, pl_o_fwd_b;
    logic [CW-1:0] pl_o_stall_cnt;
    logic          pl_o_halted;

    int checks = 0;
    int errors = 0;

    pipeline_control #(.AWIDTH(AW), .CNT_WIDTH(CW)) dut (
        .pl_clk            (pl_clk),
        .pl_rst            (pl_rst),
        .pl_i_ds_rs        (pl_i_ds_rs),
        .pl_i_ds_rt        (pl_i_ds_rt),
        .pl_i_es_rs        (pl_i_es_rs),
        .pl_i_es_rt        (pl_i_es_rt),
        .pl_i_es_rd        (pl_i_es_rd),
        .pl_i_es_memread   (pl_i_es_memread),
        .pl_i_es_change_pc (pl_i_es_change_pc),
        .pl_i_es_md_start  (pl_i_es_md_start),
        .pl_i_md_done      (pl_i_md_done),
        .pl_i_ms_rd        (pl_i_ms_rd),
        .pl_i_ws_rd        (pl_i_ws_rd),
        .pl_i_ms_regwrite  (pl_i_ms_regwrite),
        .pl_i_ws_regwrite  (pl_i_ws_regwrite),
        .pl_i_halt         (pl_i_halt),
        .pl_o_fs_ce        (pl_o_fs_ce),
        .pl_o_ds_ce        (pl_o_ds_ce),
        .pl_o_es_ce        (pl_o_es_ce),
        .pl_o_ds_flush     (pl_o_ds_flush),
        .pl_o_es_flush     (pl_o_es_flush),
        .pl_o_fwd_a        (pl_o_fwd_a),
        .pl_o_fwd_b        (pl_o_fwd_b),
        .pl_o_stall_cnt    (pl_o_stall_cnt),
        .pl_o_halted       (pl_o_halted)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {fs_ce, ds_ce, es_ce} and {ds_flush, es_flush}
    function automatic logic [31:0] ce3();
        return 32'({pl_o_fs_ce, pl_o_ds_ce, pl_o_es_ce});
    endfunction

    function automatic logic [31:0] fl2();
        return 32'({pl_o_ds_flush, pl_o_es_flush});
    endfunction

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic clear_inputs();
        pl_i_ds_rs = '0; pl_i_ds_rt = '0; pl_i_es_rs = '0; pl_i_es_rt = '0; pl_i_es_rd = '0;
        pl_i_es_memread = 1'b0; pl_i_es_change_pc = 1'b0; pl_i_es_md_start = 1'b0;
        pl_i_md_done = 1'b0; pl_i_ms_rd = '0; pl_i_ws_rd = '0;
        pl_i_ms_regwrite = 1'b0; pl_i_ws_regwrite = 1'b0; pl_i_halt = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        pl_rst = 1'b1;
        tick();
        tick();
        pl_rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        pl_rst = 1'b1;
        // A forwarding match during reset must still read as regfile.
        pl_i_ms_rd = 5'd3; pl_i_ms_regwrite = 1'b1; pl_i_es_rs = 5'd3;
        #2;
        check("rst_ce",     ce3(), 32'h0);
        check("rst_flush",  fl2(), 32'h0);
        check("rst_fwd_a",  32'(pl_o_fwd_a), 32'h0);
        check("rst_cnt",    32'(pl_o_stall_cnt), 32'h0);
        check("rst_halted", 32'(pl_o_halted), 32'h0);
        do_reset();

        // Load-use: one stall, then the consumer forwards from memory
        pl_i_es_memread = 1'b1; pl_i_es_rd = 5'd3; pl_i_ds_rs = 5'd3;
        #1;
        check("lu_ce",    ce3(), 32'h1);
        check("lu_flush", fl2(), 32'h1);
        tick();
        clear_inputs();
        pl_i_ms_rd = 5'd3; pl_i_ms_regwrite = 1'b1; pl_i_es_rs = 5'd3;
        #1;
        check("lu_fwd_a",  32'(pl_o_fwd_a), 32'h1);
        check("lu_ce_nxt", ce3(), 32'h7);
        check("lu_cnt",    32'(pl_o_stall_cnt), 32'h1);

        // Load from r0 never stalls
        clear_inputs();
        pl_i_es_memread = 1'b1; pl_i_es_rd = 5'd0; pl_i_ds_rs = 5'd0;
        #1;
        check("lu_r0_ce", ce3(), 32'h7);

        // Branch and load-use together: flush only, no stall
        do_reset();
        pl_i_es_change_pc = 1'b1; pl_i_es_memread = 1'b1; pl_i_es_rd = 5'd3; pl_i_ds_rt = 5'd3;
        #1;
        check("br_ce",    ce3(), 32'h7);
        check("br_flush", fl2(), 32'h3);
        tick();
        clear_inputs();
        #1;
        check("br_cnt", 32'(pl_o_stall_cnt), 32'h0);

        // Mul/div: start at cycle 0, done at cycle 4
        do_reset();
        pl_i_es_md_start = 1'b1;
        #1;
        check("md_c0_ce", ce3(), 32'h0);
        tick();
        pl_i_es_md_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check("md_wait_ce", ce3(), 32'h0);
            tick();
        end
        pl_i_md_done = 1'b1;
        #1;
        check("md_c4_ce",    ce3(), 32'h0);
        check("md_c4_flush", fl2(), 32'h0);
        tick();
        pl_i_md_done = 1'b0;
        #1;
        check("md_c5_ce",  ce3(), 32'h7);
        check("md_c5_cnt", 32'(pl_o_stall_cnt), 32'h5);

        // md_done coincident with md_start is ignored: minimum wait is one cycle
        do_reset();
        pl_i_es_md_start = 1'b1; pl_i_md_done = 1'b1;
        tick();
        pl_i_es_md_start = 1'b0; pl_i_md_done = 1'b0;
        #1;
        check("md_min_ce", ce3(), 32'h0);
        pl_i_md_done = 1'b1;
        tick();
        pl_i_md_done = 1'b0;
        #1;
        check("md_min_ce_run", ce3(), 32'h7);
        check("md_min_cnt",    32'(pl_o_stall_cnt), 32'h2);

        // Forwarding priority
        clear_inputs();
        pl_i_ms_rd = 5'd7; pl_i_ws_rd = 5'd7; pl_i_ms_regwrite = 1'b1; pl_i_ws_regwrite = 1'b1;
        pl_i_es_rt = 5'd7;
        #1;
        check("fwd_b_ms", 32'(pl_o_fwd_b), 32'h1);
        pl_i_ms_regwrite = 1'b0;
        #1;
        check("fwd_b_ws", 32'(pl_o_fwd_b), 32'h2);
        pl_i_ms_regwrite = 1'b1; pl_i_ms_rd = 5'd0; pl_i_ws_rd = 5'd0; pl_i_es_rt = 5'd0;
        #1;
        check("fwd_b_r0", 32'(pl_o_fwd_b), 32'h0);
        pl_i_ws_rd = 5'd9; pl_i_es_rs = 5'd9;
        #1;
        check("fwd_a_ws", 32'(pl_o_fwd_a), 32'h2);
        clear_inputs();

        // Halt: sticky, counter frozen after the request cycle
        do_reset();
        pl_i_halt = 1'b1;
        #1;
        check("halt_req_ce", ce3(), 32'h0);
        tick();
        pl_i_halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("halt_ce", ce3(), 32'h0);
        end
        check("halt_flag", 32'(pl_o_halted), 32'h1);
        check("halt_cnt",  32'(pl_o_stall_cnt), 32'h1);

        // Reset in the middle of a mul/div wait
        do_reset();
        pl_i_es_md_start = 1'b1;
        tick();
        pl_i_es_md_start = 1'b0;
        tick();
        pl_i_ms_rd = 5'd3; pl_i_ms_regwrite = 1'b1; pl_i_es_rs = 5'd3;
        pl_rst = 1'b1;
        #1;
        check("mdrst_cnt",    32'(pl_o_stall_cnt), 32'h0);
        check("mdrst_halted", 32'(pl_o_halted), 32'h0);
        check("mdrst_ce",     ce3(), 32'h0);
        check("mdrst_fwd_a",  32'(pl_o_fwd_a), 32'h0);
        tick();
        pl_rst = 1'b0;
        pl_i_md_done = 1'b1;
        #1;
        check("mdrst_ce_rel", ce3(), 32'h7);
        tick();
        pl_i_md_done = 1'b0;
        #1;
        check("mdrst_ce_run", ce3(), 32'h7);
        check("mdrst_cnt2",   32'(pl_o_stall_cnt), 32'h0);

        // Halt during mul/div wait takes effect after returning to RUN
        do_reset();
        pl_i_es_md_start = 1'b1;
        tick();
        pl_i_es_md_start = 1'b0;
        pl_i_halt = 1'b1;
        tick();
        pl_i_halt = 1'b0;
        pl_i_md_done = 1'b1;
        #1;
        check("dhalt_wait_flag", 32'(pl_o_halted), 32'h0);
        tick();
        pl_i_md_done = 1'b0;
        #1;
        check("dhalt_run_ce", ce3(), 32'h0);
        tick();
        check("dhalt_flag", 32'(pl_o_halted), 32'h1);

        // Counter saturation with a mul/div that never completes
        do_reset();
        pl_i_es_md_start = 1'b1;
        tick();
        pl_i_es_md_start = 1'b0;
        repeat (13) tick();
        check("sat_cnt_14", 32'(pl_o_stall_cnt), 32'he);
        repeat (6) tick();
        check("sat_cnt_15", 32'(pl_o_stall_cnt), 32'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
